decode_stage_pipe: RTL and testbench

- Registered decode stage for the 6-stage pipeline. Accepts one 32-bit instruction per cycle from IF/ID over a valid/ready handshake.
- Decodes the opcode into the control bundle (RegWrite, MemtoReg, MemWrite, ALUOp, ALUSrc, RegDst, Jump, MemRead), extracts register fields and the sign-extended immediate, and holds the result in the ID/EX register.
- Adds what the combinational decoder lacks: load-use hazard stall/bubble insertion, flush, illegal-opcode flagging, parametrised widths and a stall counter.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/decode_ctrl_table.sv | 49 ++++
 rtl/decode_stage_pipe.sv | 130 +++++++++++++
 tb/tb_decode_stage_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared decode definitions for the pipeline: opcodes, ALUOp classes and the
// control bundle carried from ID into EX.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memWrite;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       regDst;
    logic       jump;
    logic       memRead;
  } ctrl_bundle_t;

  // Opcodes that read rt as a source operand (and so can hit a load-use hazard on rt).
  function automatic logic usesRt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_ctrl_table.sv
// Combinational opcode decoder: opcode -> control bundle, plus an illegal flag
// for anything outside the table (controls forced to 0 in that case).
module decode_ctrl_table
  import pipe_pkg::*;
(
  input  logic [5:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluOp    = ALUOP_FUNCT;
        ctrl.regDst   = 1'b1;
      end
      OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memRead  = 1'b1;
      end
      OP_SW: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluOp    = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
      end
      OP_J: begin
        ctrl.jump     = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: decodes one instruction per cycle into the ID/EX
// register with load-use interlock, flush and a saturating bubble counter.
module decode_stage_pipe
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_reg_write,
  output logic               out_mem_to_reg,
  output logic               out_mem_write,
  output logic               out_alu_src,
  output logic               out_reg_dst,
  output logic               out_jump,
  output logic               out_mem_read,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_jump_target,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   stall_count
);

  // Handshake: a word moves on in_valid && in_ready (and out_valid && out_ready);
  // the ID/EX entry holds unchanged while out_valid && !out_ready.
  typedef struct packed {
    logic             valid;
    ctrl_bundle_t     ctrl;
    logic             illegal;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  jumpTarget;
  } idex_t;

  logic [5:0]       opcode;
  ctrl_bundle_t     decCtrl;
  logic             decIllegal;
  logic [REG_W-1:0] inRs;
  logic [REG_W-1:0] inRt;
  logic             hazard;
  logic             accept;
  idex_t            decEntry;
  idex_t            idEx;
  logic [CNT_W-1:0] stallCount;

  assign opcode = in_instr[31:26];
  assign inRs   = REG_W'(in_instr[25:21]);
  assign inRt   = REG_W'(in_instr[20:16]);

  decode_ctrl_table uCtrlTable (
    .opcode  (opcode),
    .ctrl    (decCtrl),
    .illegal (decIllegal)
  );

  always_comb begin
    decEntry            = '0;
    decEntry.valid      = 1'b1;
    decEntry.ctrl       = decCtrl;
    decEntry.illegal    = decIllegal;
    decEntry.rs         = inRs;
    decEntry.rt         = inRt;
    decEntry.rd         = REG_W'(in_instr[15:11]);
    decEntry.imm        = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
    decEntry.pc         = in_pc;
    decEntry.jumpTarget = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
  end

  // Load-use: the load in ID/EX writes a register the incoming instruction reads; $0 never counts.
  assign hazard = HAZARD_EN && in_valid && idEx.valid && idEx.ctrl.memRead &&
                  (idEx.rt != '0) &&
                  ((idEx.rt == inRs) || (usesRt(opcode) && (idEx.rt == inRt)));

  assign in_ready = flush || (!hazard && (!idEx.valid || out_ready));
  assign accept   = in_valid && in_ready;

  // Every invalid slot is fully zeroed so no control bit leaks from a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idEx       <= '0;
      stallCount <= '0;
    end else if (flush) begin
      idEx <= '0;
    end else if (hazard && out_ready) begin
      idEx <= '0;
      if (stallCount != '1) stallCount <= stallCount + CNT_W'(1);
    end else if (accept) begin
      idEx <= decEntry;
    end else if (out_ready) begin
      idEx <= '0;
    end
  end

  assign out_valid       = idEx.valid;
  assign out_reg_write   = idEx.ctrl.regWrite;
  assign out_mem_to_reg  = idEx.ctrl.memToReg;
  assign out_mem_write   = idEx.ctrl.memWrite;
  assign out_alu_src     = idEx.ctrl.aluSrc;
  assign out_reg_dst     = idEx.ctrl.regDst;
  assign out_jump        = idEx.ctrl.jump;
  assign out_mem_read    = idEx.ctrl.memRead;
  assign out_alu_op      = ALUOP_W'(idEx.ctrl.aluOp);
  assign out_rs          = idEx.rs;
  assign out_rt          = idEx.rt;
  assign out_rd          = idEx.rd;
  assign out_imm         = idEx.imm;
  assign out_pc          = idEx.pc;
  assign out_jump_target = idEx.jumpTarget;
  assign out_illegal     = idEx.illegal;
  assign stall_count     = stallCount;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic        out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src;
  logic        out_reg_dst, out_jump, out_mem_read;
  logic [1:0]  out_alu_op;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [31:0] out_imm, out_pc, out_jump_target;
  logic        out_illegal;
  logic [15:0] stall_count;

  decode_stage_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_reg_write   (out_reg_write),
    .out_mem_to_reg  (out_mem_to_reg),
    .out_mem_write   (out_mem_write),
    .out_alu_src     (out_alu_src),
    .out_reg_dst     (out_reg_dst),
    .out_jump        (out_jump),
    .out_mem_read    (out_mem_read),
    .out_alu_op      (out_alu_op),
    .out_rs          (out_rs),
    .out_rt          (out_rt),
    .out_rd          (out_rd),
    .out_imm         (out_imm),
    .out_pc          (out_pc),
    .out_jump_target (out_jump_target),
    .out_illegal     (out_illegal),
    .stall_count     (stall_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int checkCount = 0;
  int passCount  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // ctl order: RegWrite, MemtoReg, MemWrite, ALUOp[1:0], ALUSrc, RegDst, Jump, MemRead
  typedef struct packed {
    logic [8:0]  ctl;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] jt;
  } expEntry_t;

  function automatic expEntry_t expDecode(input logic [31:0] ins, input logic [31:0] pc);
    expEntry_t e;
    int immVal;
    e = '0;
    case (ins[31:26])
      6'h00:   e.ctl = 9'b1_0_0_10_0_1_0_0;
      6'h23:   e.ctl = 9'b1_1_0_00_1_0_0_1;
      6'h2B:   e.ctl = 9'b0_0_1_00_1_0_0_0;
      6'h04:   e.ctl = 9'b0_0_0_01_0_0_0_0;
      6'h08:   e.ctl = 9'b1_0_0_00_1_0_0_0;
      6'h02:   e.ctl = 9'b0_0_0_00_0_0_1_0;
      default: e.illegal = 1'b1;
    endcase
    e.rs   = ins[25:21];
    e.rt   = ins[20:16];
    e.rd   = ins[15:11];
    immVal = $signed(ins[15:0]);
    e.imm  = immVal;
    e.pc   = pc;
    e.jt   = (pc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    return e;
  endfunction

  logic        mValid;
  expEntry_t   mE;
  logic [15:0] mStalls;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  function automatic logic modelHazard();
    logic [5:0] op;
    logic       rtRead;
    op     = in_instr[31:26];
    rtRead = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return in_valid && mValid && mE.ctl[0] && (mE.rt != 5'd0) &&
           ((mE.rt == in_instr[25:21]) || (rtRead && mE.rt == in_instr[20:16]));
  endfunction

  function automatic logic modelReady();
    return flush || (!modelHazard() && (!mValid || out_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid  <= 1'b0;
      mE      <= '0;
      mStalls <= '0;
    end else begin
      if (mValid && out_ready && !flush) exp_q.push_back(mE.pc);
      if (flush) begin
        mValid <= 1'b0;
        mE     <= '0;
      end else if (modelHazard() && out_ready) begin
        mValid <= 1'b0;
        mE     <= '0;
        if (mStalls != 16'hFFFF) mStalls <= mStalls + 16'd1;
      end else if (in_valid && modelReady()) begin
        mValid <= 1'b1;
        mE     <= expDecode(in_instr, in_pc);
      end else if (out_ready) begin
        mValid <= 1'b0;
        mE     <= '0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, modelReady());
      check("out_valid", out_valid, mValid);
      check("ctl", {out_reg_write, out_mem_to_reg, out_mem_write, out_alu_op,
                    out_alu_src, out_reg_dst, out_jump, out_mem_read}, mE.ctl);
      check("illegal", out_illegal, mE.illegal);
      check("regs", {out_rs, out_rt, out_rd}, {mE.rs, mE.rt, mE.rd});
      check("imm", out_imm, mE.imm);
      check("pc", out_pc, mE.pc);
      check("jump_target", out_jump_target, mE.jt);
      check("stall_count", stall_count, mStalls);
      if (out_valid && out_ready && !flush) got_q.push_back(out_pc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] ops [8];
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [31:0] r;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};
    op  = ops[$urandom_range(0, 7)];
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    r   = $urandom;
    return {op, rs, rt, r[15:0]};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_stall", stall_count, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // back-to-back R-type then addi
    drive(1'b1, 32'h012A_4020, 32'h0000_0100, 1'b1, 1'b0);
    tick();
    check("rtype_valid", out_valid, 1'b1);
    check("rtype_ctl", {out_reg_write, out_mem_to_reg, out_mem_write, out_alu_op,
                        out_alu_src, out_reg_dst, out_jump, out_mem_read}, 9'b1_0_0_10_0_1_0_0);
    check("rtype_regs", {out_rs, out_rt, out_rd}, {5'd9, 5'd10, 5'd8});
    drive(1'b1, 32'h2008_0005, 32'h0000_0104, 1'b1, 1'b0);
    tick();
    check("addi_valid", out_valid, 1'b1);
    check("addi_ctl", {out_reg_write, out_mem_to_reg, out_mem_write, out_alu_op,
                       out_alu_src, out_reg_dst, out_jump, out_mem_read}, 9'b1_0_0_00_1_0_0_0);
    check("addi_imm", out_imm, 32'd5);

    // load-use: one bubble
    drive(1'b1, 32'h8D09_0000, 32'h0000_0108, 1'b1, 1'b0);
    tick();
    check("lw_mem_read", out_mem_read, 1'b1);
    drive(1'b1, 32'h012A_4020, 32'h0000_010C, 1'b1, 1'b0);
    #1;
    check("lu_in_ready", in_ready, 1'b0);
    tick();
    check("lu_bubble", out_valid, 1'b0);
    check("lu_stall", stall_count, 16'd1);
    tick();
    check("lu_add_valid", out_valid, 1'b1);
    check("lu_add_pc", out_pc, 32'h0000_010C);

    // load to $0 does not stall
    drive(1'b1, 32'h8D00_0000, 32'h0000_0110, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0000_4020, 32'h0000_0114, 1'b1, 1'b0);
    #1;
    check("r0_in_ready", in_ready, 1'b1);
    tick();
    check("r0_pc", out_pc, 32'h0000_0114);
    check("r0_stall", stall_count, 16'd1);

    // backpressure: 3 held cycles
    drive(1'b1, 32'h0109_5020, 32'h0000_0200, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h012A_4020, 32'h0000_0204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_pc", out_pc, 32'h0000_0200);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_pc", out_pc, 32'h0000_0204);

    // hazard while EX is stalled: load held, no bubble counted
    drive(1'b1, 32'h8D09_0000, 32'h0000_0300, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h012A_4020, 32'h0000_0304, 1'b0, 1'b0);
    repeat (2) tick();
    check("hz_hold_pc", out_pc, 32'h0000_0300);
    check("hz_hold_stall", stall_count, 16'd1);
    out_ready = 1'b1;
    tick();
    check("hz_bubble_stall", stall_count, 16'd2);
    tick();
    check("hz_add_pc", out_pc, 32'h0000_0304);

    // flush during hazard, then illegal and jump
    drive(1'b1, 32'h8D09_0000, 32'h0000_0400, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h012A_4020, 32'h0000_0404, 1'b1, 1'b1);
    #1;
    check("fl_in_ready", in_ready, 1'b1);
    tick();
    check("fl_valid", out_valid, 1'b0);
    check("fl_stall", stall_count, 16'd2);
    drive(1'b1, 32'hFC00_0000, 32'h0000_0408, 1'b1, 1'b0);
    tick();
    check("ill_valid", out_valid, 1'b1);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_ctl", {out_reg_write, out_mem_to_reg, out_mem_write, out_alu_op,
                      out_alu_src, out_reg_dst, out_jump, out_mem_read}, 9'd0);
    drive(1'b1, 32'h0800_0010, 32'h1000_0004, 1'b1, 1'b0);
    tick();
    check("j_jump", out_jump, 1'b1);
    check("j_target", out_jump_target, 32'h1000_0040);

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_stall", stall_count, 16'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = randInstr();
      in_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) tick();

    check("xfer_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check("xfer_pc", got_q[k], exp_q[k]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
